// File: rtl/button_debouncer_if.sv
// button_debouncer_if: raw button input and debounced outputs of one button channel
interface button_debouncer_if #(parameter int PRESS_CNT_W = 8);
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic [PRESS_CNT_W-1:0] press_count;
  modport master(output btn_raw, input btn_level, press_pulse, release_pulse, press_count);
  modport slave(input btn_raw, output btn_level, press_pulse, release_pulse, press_count);
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop sync, stability-counted FSM, press/release strobes and press counter
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PRESS_CNT_W     = 8,
  parameter bit ACTIVE_LOW_BTN  = 1'b0
) (
  input logic clk,
  input logic rst_ext_n,
  button_debouncer_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;
  state_t state;
  logic sync1, sync2, s;
  logic [CW-1:0] stab_cnt;
  assign s = sync2 ^ ACTIVE_LOW_BTN;
  // sync flops reset to the idle pin level so the logical input reads released
  always_ff @(posedge clk or negedge rst_ext_n)
    if (!rst_ext_n) begin
      sync1             <= ACTIVE_LOW_BTN;
      sync2             <= ACTIVE_LOW_BTN;
      state             <= STABLE_LO;
      stab_cnt          <= '0;
      bus.btn_level     <= 1'b0;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.press_count   <= '0;
    end else begin
      sync1             <= bus.btn_raw;
      sync2             <= sync1;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      case (state)
        STABLE_LO: if (s) begin
          state    <= CHK_HI;
          stab_cnt <= '0;
        end
        CHK_HI: if (!s) state <= STABLE_LO;
        else if (stab_cnt == LAST) begin
          state           <= STABLE_HI;
          bus.btn_level   <= 1'b1;
          bus.press_pulse <= 1'b1;
          bus.press_count <= bus.press_count + PRESS_CNT_W'(1);
        end else stab_cnt <= stab_cnt + 1'b1;
        STABLE_HI: if (!s) begin
          state    <= CHK_LO;
          stab_cnt <= '0;
        end
        CHK_LO: if (s) state <= STABLE_HI;
        else if (stab_cnt == LAST) begin
          state             <= STABLE_LO;
          bus.btn_level     <= 1'b0;
          bus.release_pulse <= 1'b1;
        end else stab_cnt <= stab_cnt + 1'b1;
      endcase
    end
endmodule
